// File: rtl/phrase_player_if.sv
// Bundles the phrase_player control, table-lookup and note-output signals.
// With PHRASE_PLAYER_LOOP_EN defined, a 2-bit repeat_n request is added and is latched with start.
interface phrase_player_if #(
  parameter int NOTE_W    = 4,
  parameter int MAX_NOTES = 8,
  parameter int ADDR_W    = 4
);
  localparam int CNT_W = (MAX_NOTES > 1) ? $clog2(MAX_NOTES) : 1;

  logic                        start;
  logic [ADDR_W-1:0]           phrase_sel;
  logic                        abort;
  logic                        tick;
  logic [ADDR_W-1:0]           db_addr;
  logic [NOTE_W*MAX_NOTES-1:0] db_entry;
  logic [MAX_NOTES-1:0]        length_entry;
  logic [CNT_W-1:0]            n_note;
  logic                        ready;
  logic                        busy;
  logic [NOTE_W-1:0]           note_code;
  logic                        note_on;
  logic                        note_strobe;
  logic                        done;
`ifdef PHRASE_PLAYER_LOOP_EN
  logic [1:0]                  repeat_n;

  modport master (
    output start, phrase_sel, abort, tick, db_entry, length_entry, n_note, repeat_n,
    input  db_addr, ready, busy, note_code, note_on, note_strobe, done
  );
  modport slave (
    input  start, phrase_sel, abort, tick, db_entry, length_entry, n_note, repeat_n,
    output db_addr, ready, busy, note_code, note_on, note_strobe, done
  );
`else
  modport master (
    output start, phrase_sel, abort, tick, db_entry, length_entry, n_note,
    input  db_addr, ready, busy, note_code, note_on, note_strobe, done
  );
  modport slave (
    input  start, phrase_sel, abort, tick, db_entry, length_entry, n_note,
    output db_addr, ready, busy, note_code, note_on, note_strobe, done
  );
`endif
endinterface

// File: rtl/phrase_player.sv
// Phrase playback engine: fetches one packed phrase, then steps through its notes on tempo ticks.
// Optional PHRASE_PLAYER_LOOP_EN replays the latched phrase repeat_n+1 times without refetching.
module phrase_player #(
  parameter int NOTE_W     = 4,
  parameter int MAX_NOTES  = 8,
  parameter int ADDR_W     = 4,
  parameter int LONG_TICKS = 2,
  parameter int REST_CODE  = 7
) (
  input  logic           clk,
  input  logic           rst,
  phrase_player_if.slave pif
);
  localparam int CNT_W = (MAX_NOTES > 1) ? $clog2(MAX_NOTES) : 1;
  localparam int DUR_W = (LONG_TICKS > 2) ? $clog2(LONG_TICKS) : 1;
  localparam logic [NOTE_W-1:0] REST     = NOTE_W'(REST_CODE);
  localparam logic [DUR_W-1:0]  DUR_LONG = DUR_W'(LONG_TICKS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_WAIT, ST_PLAY} state_t;

  state_t                      state_q, state_d;
  logic [ADDR_W-1:0]           db_addr_q, db_addr_d;
  logic [NOTE_W*MAX_NOTES-1:0] entry_q, entry_d;
  logic [MAX_NOTES-1:0]        len_q, len_d;
  logic [CNT_W-1:0]            last_q, last_d;
  logic [CNT_W-1:0]            idx_q, idx_d;
  logic [DUR_W-1:0]            dur_q, dur_d;
  logic [NOTE_W-1:0]           code_q, code_d;
  logic                        on_q, on_d;
  logic                        strobe_q, strobe_d;
  logic                        done_q, done_d;
  logic                        present;
  logic [CNT_W-1:0]            pidx;
`ifdef PHRASE_PLAYER_LOOP_EN
  logic [1:0]                  reps_q, reps_d;
`endif

  // Slot 0 lives in the most significant field of both packed words.
  function automatic logic [NOTE_W-1:0] slot_code(input logic [NOTE_W*MAX_NOTES-1:0] ent,
                                                  input logic [CNT_W-1:0] i);
    return ent[NOTE_W*(MAX_NOTES-1-int'(i)) +: NOTE_W];
  endfunction

  function automatic logic slot_long(input logic [MAX_NOTES-1:0] len, input logic [CNT_W-1:0] i);
    return len[MAX_NOTES-1-int'(i)];
  endfunction

  always_comb begin
    state_d   = state_q;
    db_addr_d = db_addr_q;
    entry_d   = entry_q;
    len_d     = len_q;
    last_d    = last_q;
    idx_d     = idx_q;
    dur_d     = dur_q;
    code_d    = code_q;
    on_d      = on_q;
    strobe_d  = 1'b0;
    done_d    = 1'b0;
    present   = 1'b0;
    pidx      = '0;
`ifdef PHRASE_PLAYER_LOOP_EN
    reps_d    = reps_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (pif.start) begin
          db_addr_d = pif.phrase_sel;
`ifdef PHRASE_PLAYER_LOOP_EN
          reps_d    = pif.repeat_n;
`endif
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        entry_d = pif.db_entry;
        len_d   = pif.length_entry;
        last_d  = pif.n_note;
        idx_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (pif.tick) begin
          present = 1'b1;
          pidx    = '0;
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (pif.tick) begin
          if (dur_q != '0) begin
            dur_d = dur_q - 1'b1;
          end else if (idx_q < last_q) begin
            present = 1'b1;
            pidx    = idx_q + 1'b1;
          end else begin
`ifdef PHRASE_PLAYER_LOOP_EN
            if (reps_q != 2'd0) begin
              reps_d  = reps_q - 2'd1;
              present = 1'b1;
              pidx    = '0;
            end else begin
              done_d  = 1'b1;
              on_d    = 1'b0;
              code_d  = REST;
              state_d = ST_IDLE;
            end
`else
            done_d  = 1'b1;
            on_d    = 1'b0;
            code_d  = REST;
            state_d = ST_IDLE;
`endif
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (present) begin
      idx_d    = pidx;
      code_d   = slot_code(entry_q, pidx);
      on_d     = (slot_code(entry_q, pidx) != REST);
      strobe_d = 1'b1;
      dur_d    = slot_long(len_q, pidx) ? DUR_LONG : '0;
    end

    // Abort wins over everything the FSM decided this cycle.
    if (pif.abort) begin
      state_d   = ST_IDLE;
      db_addr_d = db_addr_q;
      code_d    = REST;
      on_d      = 1'b0;
      strobe_d  = 1'b0;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      db_addr_q <= '0;
      idx_q     <= '0;
      dur_q     <= '0;
      code_q    <= REST;
      on_q      <= 1'b0;
      strobe_q  <= 1'b0;
      done_q    <= 1'b0;
`ifdef PHRASE_PLAYER_LOOP_EN
      reps_q    <= 2'd0;
`endif
    end else begin
      state_q   <= state_d;
      db_addr_q <= db_addr_d;
      idx_q     <= idx_d;
      dur_q     <= dur_d;
      code_q    <= code_d;
      on_q      <= on_d;
      strobe_q  <= strobe_d;
      done_q    <= done_d;
`ifdef PHRASE_PLAYER_LOOP_EN
      reps_q    <= reps_d;
`endif
    end
  end

  // Latched phrase contents are only meaningful after LOAD, so they carry no reset.
  always_ff @(posedge clk) begin
    entry_q <= entry_d;
    len_q   <= len_d;
    last_q  <= last_d;
  end

  assign pif.db_addr     = db_addr_q;
  assign pif.note_code   = code_q;
  assign pif.note_on     = on_q;
  assign pif.note_strobe = strobe_q;
  assign pif.done        = done_q;
  assign pif.ready       = (state_q == ST_IDLE);
  assign pif.busy        = (state_q != ST_IDLE);
endmodule

// File: tb/tb_phrase_player.sv
// Directed bench for phrase_player: a small phrase table keyed by db_addr, checked tick by tick.
module tb_phrase_player;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   errs = 0;
  int   stb_total = 0;
  int   done_total = 0;
  int   on_total = 0;
  int   stb_base, done_base, on_base;

  always #5 clk = ~clk;

  phrase_player_if #(.NOTE_W(4), .MAX_NOTES(8), .ADDR_W(4)) pif ();

  phrase_player #(
    .NOTE_W(4), .MAX_NOTES(8), .ADDR_W(4), .LONG_TICKS(2), .REST_CODE(7)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pif(pif)
  );

  always_comb begin
    case (pif.db_addr)
      4'd1:    begin pif.db_entry = 32'h89899777; pif.length_entry = 8'b01011000; pif.n_note = 3'd4; end
      4'd2:    begin pif.db_entry = 32'h77777777; pif.length_entry = 8'b00000000; pif.n_note = 3'd7; end
      default: begin pif.db_entry = 32'h11272020; pif.length_entry = 8'b10000000; pif.n_note = 3'd6; end
    endcase
  end

  always @(negedge clk) begin
    if (pif.note_strobe) stb_total  <= stb_total + 1;
    if (pif.done)        done_total <= done_total + 1;
    if (pif.note_on)     on_total   <= on_total + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tk(input string tag, input logic [3:0] c, input logic on, input logic stb,
                    input logic dn);
    pif.tick = 1'b1;
    step();
    pif.tick = 1'b0;
    chk({tag, ".code"}, 32'(pif.note_code), 32'(c));
    chk({tag, ".on"}, 32'(pif.note_on), 32'(on));
    chk({tag, ".strobe"}, 32'(pif.note_strobe), 32'(stb));
    chk({tag, ".done"}, 32'(pif.done), 32'(dn));
    step();
  endtask

  task automatic kick(input logic [3:0] sel);
    pif.phrase_sel = sel;
    pif.start = 1'b1;
    step();
    pif.start = 1'b0;
    step();
    step();
  endtask

  task automatic mark();
    stb_base  = stb_total;
    done_base = done_total;
    on_base   = on_total;
  endtask

  task automatic phrase0(input string t);
    tk({t, "1"}, 4'd1, 1, 1, 0);
    tk({t, "2"}, 4'd1, 1, 0, 0);
    tk({t, "3"}, 4'd1, 1, 1, 0);
    tk({t, "4"}, 4'd2, 1, 1, 0);
    tk({t, "5"}, 4'd7, 0, 1, 0);
    tk({t, "6"}, 4'd2, 1, 1, 0);
    tk({t, "7"}, 4'd0, 1, 1, 0);
    tk({t, "8"}, 4'd2, 1, 1, 0);
    tk({t, "9"}, 4'd7, 0, 0, 1);
  endtask

  task automatic phrase1(input string t);
    tk({t, "1"}, 4'd8, 1, 1, 0);
    tk({t, "2"}, 4'd9, 1, 1, 0);
    tk({t, "3"}, 4'd9, 1, 0, 0);
    tk({t, "4"}, 4'd8, 1, 1, 0);
    tk({t, "5"}, 4'd9, 1, 1, 0);
    tk({t, "6"}, 4'd9, 1, 0, 0);
    tk({t, "7"}, 4'd9, 1, 1, 0);
    tk({t, "8"}, 4'd9, 1, 0, 0);
    tk({t, "9"}, 4'd7, 0, 0, 1);
  endtask

  initial begin
    pif.start = 1'b0;
    pif.phrase_sel = '0;
    pif.abort = 1'b0;
    pif.tick = 1'b0;
`ifdef PHRASE_PLAYER_LOOP_EN
    pif.repeat_n = 2'd0;
`endif
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst.ready", 32'(pif.ready), 32'd1);
    chk("rst.busy", 32'(pif.busy), 32'd0);
    chk("rst.code", 32'(pif.note_code), 32'd7);
    chk("rst.on", 32'(pif.note_on), 32'd0);
    chk("rst.addr", 32'(pif.db_addr), 32'd0);

    // Phrase 0: long first slot, rest in slot 3.
    mark();
    kick(4'd0);
    chk("a.busy", 32'(pif.busy), 32'd1);
    phrase0("a.t");
    step();
    chk("a.ready", 32'(pif.ready), 32'd1);
    chk("a.strobes", 32'(stb_total - stb_base), 32'd7);
    chk("a.dones", 32'(done_total - done_base), 32'd1);

    // Phrase 1: mixed durations 1,2,1,2,2.
    mark();
    kick(4'd1);
    chk("b.addr", 32'(pif.db_addr), 32'd1);
    phrase1("b.t");
    step();
    chk("b.strobes", 32'(stb_total - stb_base), 32'd5);

    // Phrase 2: all eight slots are rests.
    mark();
    kick(4'd2);
    chk("c.addr", 32'(pif.db_addr), 32'd2);
    for (int i = 0; i < 8; i++) tk("c.t", 4'd7, 0, 1, 0);
    tk("c.t9", 4'd7, 0, 0, 1);
    step();
    chk("c.strobes", 32'(stb_total - stb_base), 32'd8);
    chk("c.on", 32'(on_total - on_base), 32'd0);

    // Tick coincident with start, then repeated starts while busy.
    mark();
    pif.phrase_sel = 4'd0;
    pif.start = 1'b1;
    pif.tick = 1'b1;
    step();
    pif.tick = 1'b0;
    pif.phrase_sel = 4'd1;
    step();
    chk("d.strobe", 32'(pif.note_strobe), 32'd0);
    chk("d.addr", 32'(pif.db_addr), 32'd0);
    step();
    pif.start = 1'b0;
    step();
    chk("d.busy", 32'(pif.busy), 32'd1);
    chk("d.addr2", 32'(pif.db_addr), 32'd0);
    phrase0("d.t");

    // Abort while a sounding note is held.
    mark();
    kick(4'd0);
    tk("e.t1", 4'd1, 1, 1, 0);
    tk("e.t2", 4'd1, 1, 0, 0);
    tk("e.t3", 4'd1, 1, 1, 0);
    tk("e.t4", 4'd2, 1, 1, 0);
    pif.abort = 1'b1;
    step();
    pif.abort = 1'b0;
    chk("e.ready", 32'(pif.ready), 32'd1);
    chk("e.on", 32'(pif.note_on), 32'd0);
    chk("e.code", 32'(pif.note_code), 32'd7);
    chk("e.done", 32'(pif.done), 32'd0);
    step();
    chk("e.dones", 32'(done_total - done_base), 32'd0);
    kick(4'd1);
    phrase1("e.r");

    // Synchronous reset in the middle of playback.
    kick(4'd1);
    tk("f.t1", 4'd8, 1, 1, 0);
    tk("f.t2", 4'd9, 1, 1, 0);
    rst = 1'b1;
    step();
    chk("f.addr", 32'(pif.db_addr), 32'd0);
    chk("f.code", 32'(pif.note_code), 32'd7);
    chk("f.on", 32'(pif.note_on), 32'd0);
    chk("f.ready", 32'(pif.ready), 32'd1);
    chk("f.busy", 32'(pif.busy), 32'd0);
    rst = 1'b0;
    step();

`ifdef PHRASE_PLAYER_LOOP_EN
    // Three passes of phrase 0 from a single fetch.
    mark();
    pif.repeat_n = 2'd2;
    kick(4'd0);
    pif.repeat_n = 2'd0;
    for (int i = 0; i < 8; i++) begin
      pif.tick = 1'b1; step(); pif.tick = 1'b0; step();
    end
    tk("g.wrap", 4'd1, 1, 1, 0);
    for (int i = 0; i < 15; i++) begin
      pif.tick = 1'b1; step(); pif.tick = 1'b0; step();
    end
    chk("g.nodone", 32'(done_total - done_base), 32'd0);
    tk("g.end", 4'd7, 0, 0, 1);
    step();
    chk("g.strobes", 32'(stb_total - stb_base), 32'd21);
    chk("g.dones", 32'(done_total - done_base), 32'd1);
    chk("g.ready", 32'(pif.ready), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
